traffic_light_multi: RTL and testbench

//  N-way round-robin intersection controller. Generalises the two-way fixed-sequence controller.

---
 rtl/traffic_light_pkg.sv | 24 ++
 rtl/traffic_light_multi_phase_timer.sv | 36 +++
 rtl/traffic_light_multi.sv | 182 ++++++++++++++++++
 tb/tb_traffic_light_multi.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// Shared phase encodings and the phase -> duration selector for the intersection controller.
package traffic_light_pkg;

    localparam logic [1:0] PH_GREEN  = 2'b00;
    localparam logic [1:0] PH_YELLOW = 2'b01;
    localparam logic [1:0] PH_ALLRED = 2'b10;
    localparam logic [1:0] PH_FLASH  = 2'b11;

    function automatic int unsigned phase_cycles(
        input logic [1:0]  ph,
        input int unsigned green_cyc,
        input int unsigned yellow_cyc,
        input int unsigned allred_cyc,
        input int unsigned flash_cyc
    );
        case (ph)
            PH_GREEN:  return green_cyc;
            PH_YELLOW: return yellow_cyc;
            PH_ALLRED: return allred_cyc;
            default:   return flash_cyc;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_multi_phase_timer.sv
// Phase timer: up-counter with clear, enable and saturate; terminal flags the last cycle of a phase.
module phase_timer #(
    parameter int CNT_W = 32
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             sat,
    input  logic [CNT_W-1:0] limit,
    output logic             terminal
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !sat) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal = (count_q == (limit - CNT_W'(1)));

endmodule

// File: rtl/traffic_light_multi.sv
// N-way round-robin intersection controller with all-red clearance, pause and green hold.
// Optional flash mode is compiled in when TRAFFIC_LIGHT_FLASH_EN is defined.
//
// phase     | meaning
// PH_GREEN  | active_way green, all other ways red
// PH_YELLOW | active_way yellow, all other ways red
// PH_ALLRED | clearance, every way red; exits to the next way's green
// PH_FLASH  | all yellows blink together, no red or green (flash build only)
module traffic_light_multi
    import traffic_light_pkg::*;
#(
    parameter int unsigned NUM_WAYS      = 3,
    parameter int unsigned GREEN_CYCLES  = 480_000_000,
    parameter int unsigned YELLOW_CYCLES = 80_000_000,
    parameter int unsigned ALLRED_CYCLES = 32_000_000,
    parameter int unsigned FLASH_CYCLES  = 8_000_000,
    parameter int          CNT_W         = 32,
    localparam int         WAY_W         = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                hold,
`ifdef TRAFFIC_LIGHT_FLASH_EN
    input  logic                flash,
`endif
    output logic [NUM_WAYS-1:0] red,
    output logic [NUM_WAYS-1:0] yellow,
    output logic [NUM_WAYS-1:0] green,
    output logic [WAY_W-1:0]    active_way,
    output logic [1:0]          phase
);

    logic [1:0]          phase_q,    phase_d;
    logic [WAY_W-1:0]    way_q,      way_d;
    logic                first_q,    first_d;
    logic                flash_on_q, flash_on_d;
    logic [NUM_WAYS-1:0] red_q,      red_d;
    logic [NUM_WAYS-1:0] yellow_q,   yellow_d;
    logic [NUM_WAYS-1:0] green_q,    green_d;

    logic             flash_req;
    logic             phase_bad;
    logic             illegal;
    logic [WAY_W-1:0] way_next;
    logic             tmr_clr;
    logic             tmr_sat;
    logic             tmr_term;
    logic [CNT_W-1:0] tmr_limit;
    logic [NUM_WAYS-1:0] way_oh;

`ifdef TRAFFIC_LIGHT_FLASH_EN
    assign flash_req = flash;
    assign phase_bad = 1'b0;
`else
    assign flash_req = 1'b0;
    assign phase_bad = (phase_q == PH_FLASH);
`endif

    assign illegal   = phase_bad || ({1'b0, way_q} >= (WAY_W+1)'(NUM_WAYS));
    assign way_next  = (way_q == WAY_W'(NUM_WAYS - 1)) ? '0 : way_q + 1'b1;
    assign tmr_limit = CNT_W'(phase_cycles(phase_q, GREEN_CYCLES, YELLOW_CYCLES,
                                           ALLRED_CYCLES, FLASH_CYCLES));

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr),
        .en       (enable),
        .sat      (tmr_sat),
        .limit    (tmr_limit),
        .terminal (tmr_term)
    );

    // first_q marks the post-reset clearance, which hands green to way 0 instead of way+1.
    always_comb begin
        phase_d    = phase_q;
        way_d      = way_q;
        first_d    = first_q;
        flash_on_d = flash_on_q;
        tmr_clr    = 1'b0;
        tmr_sat    = 1'b0;
        if (illegal) begin
            phase_d    = PH_ALLRED;
            way_d      = '0;
            first_d    = 1'b1;
            flash_on_d = 1'b0;
            tmr_clr    = 1'b1;
        end else if (enable) begin
            if (flash_req && (phase_q != PH_FLASH)) begin
                phase_d    = PH_FLASH;
                flash_on_d = 1'b1;
                first_d    = 1'b0;
                tmr_clr    = 1'b1;
            end else if (!flash_req && (phase_q == PH_FLASH)) begin
                phase_d    = PH_ALLRED;
                flash_on_d = 1'b0;
                tmr_clr    = 1'b1;
            end else if (tmr_term) begin
                case (phase_q)
                    PH_GREEN: begin
                        if (hold) begin
                            tmr_sat = 1'b1;
                        end else begin
                            phase_d = PH_YELLOW;
                            tmr_clr = 1'b1;
                        end
                    end
                    PH_YELLOW: begin
                        phase_d = PH_ALLRED;
                        tmr_clr = 1'b1;
                    end
                    PH_ALLRED: begin
                        phase_d = PH_GREEN;
                        tmr_clr = 1'b1;
                        first_d = 1'b0;
                        if (!first_q) begin
                            way_d = way_next;
                        end
                    end
                    default: begin
                        flash_on_d = !flash_on_q;
                        tmr_clr    = 1'b1;
                    end
                endcase
            end
        end
    end

    always_comb begin
        way_oh   = NUM_WAYS'(1) << way_d;
        red_d    = '1;
        yellow_d = '0;
        green_d  = '0;
        case (phase_d)
            PH_GREEN: begin
                red_d   = ~way_oh;
                green_d = way_oh;
            end
            PH_YELLOW: begin
                red_d    = ~way_oh;
                yellow_d = way_oh;
            end
            PH_FLASH: begin
                red_d    = '0;
                yellow_d = {NUM_WAYS{flash_on_d}};
            end
            default: begin
                red_d = '1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= PH_ALLRED;
            way_q      <= '0;
            first_q    <= 1'b1;
            flash_on_q <= 1'b0;
            red_q      <= '1;
            yellow_q   <= '0;
            green_q    <= '0;
        end else begin
            phase_q    <= phase_d;
            way_q      <= way_d;
            first_q    <= first_d;
            flash_on_q <= flash_on_d;
            red_q      <= red_d;
            yellow_q   <= yellow_d;
            green_q    <= green_d;
        end
    end

    assign red        = red_q;
    assign yellow     = yellow_q;
    assign green      = green_q;
    assign active_way = way_q;
    assign phase      = phase_q;

endmodule

// File: tb/tb_traffic_light_multi.sv
// Directed bench for traffic_light_multi (3 ways, green 4, yellow 2, all-red 1, flash 2).
// Flash scenario is exercised when TRAFFIC_LIGHT_FLASH_EN is defined.
module tb_traffic_light_multi;
    import traffic_light_pkg::*;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       hold;
`ifdef TRAFFIC_LIGHT_FLASH_EN
    logic       flash;
`endif
    logic [2:0] red;
    logic [2:0] yellow;
    logic [2:0] green;
    logic [1:0] active_way;
    logic [1:0] phase;

    int n_assert = 0;
    int n_fail   = 0;

    traffic_light_multi #(
        .NUM_WAYS      (3),
        .GREEN_CYCLES  (4),
        .YELLOW_CYCLES (2),
        .ALLRED_CYCLES (1),
        .FLASH_CYCLES  (2),
        .CNT_W         (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .hold       (hold),
`ifdef TRAFFIC_LIGHT_FLASH_EN
        .flash      (flash),
`endif
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .active_way (active_way),
        .phase      (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_st(input string tag, input logic [1:0] ph, input logic [1:0] way,
                             input logic lit);
        logic [2:0] oh, r, y, g;
        oh = 3'b001 << way;
        case (ph)
            PH_GREEN:  begin r = ~oh;    y = 3'b000;   g = oh;     end
            PH_YELLOW: begin r = ~oh;    y = oh;       g = 3'b000; end
            PH_ALLRED: begin r = 3'b111; y = 3'b000;   g = 3'b000; end
            default:   begin r = 3'b000; y = {3{lit}}; g = 3'b000; end
        endcase
        chk({tag, "/phase"},  32'(phase),      32'(ph));
        chk({tag, "/way"},    32'(active_way), 32'(way));
        chk({tag, "/red"},    32'(red),        32'(r));
        chk({tag, "/yellow"}, 32'(yellow),     32'(y));
        chk({tag, "/green"},  32'(green),      32'(g));
    endtask

    task automatic check_safety();
        int nonred;
        int bad;
        nonred = 0;
        bad    = 0;
        for (int k = 0; k < 3; k++) begin
            if (!red[k]) nonred++;
            if ((32'(red[k]) + 32'(yellow[k]) + 32'(green[k])) != 1) bad++;
        end
        chk("safe_nonred_le1", 32'(nonred <= 1), 32'd1);
        chk("lamp_one_per_way", 32'(bad), 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        hold   = 1'b0;
`ifdef TRAFFIC_LIGHT_FLASH_EN
        flash  = 1'b0;
`endif
        // reset held with enable=1: reset must win
        step();
        step();
        expect_st("reset", PH_ALLRED, 2'd0, 1'b0);

        // full rotation: allred(1) then g x4, y x2, allred x1 per way, wrapping to way 0
        rst = 1'b0;
        for (int w = 0; w < 3; w++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                expect_st("rot_green", PH_GREEN, 2'(w), 1'b0);
            end
            for (int c = 0; c < 2; c++) begin
                step();
                expect_st("rot_yellow", PH_YELLOW, 2'(w), 1'b0);
            end
            step();
            expect_st("rot_allred", PH_ALLRED, 2'(w), 1'b0);
        end
        step();
        expect_st("rot_wrap", PH_GREEN, 2'd0, 1'b0);

        // hold from green cycle 2 for 6 cycles stretches green(0) to 8 cycles
        step();
        expect_st("hold_g2", PH_GREEN, 2'd0, 1'b0);
        hold = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            expect_st("hold_green", PH_GREEN, 2'd0, 1'b0);
        end
        hold = 1'b0;
        step();
        expect_st("hold_release_yellow", PH_YELLOW, 2'd0, 1'b0);
        step();
        expect_st("hold_yellow2", PH_YELLOW, 2'd0, 1'b0);
        step();
        expect_st("hold_allred", PH_ALLRED, 2'd0, 1'b0);
        step();
        expect_st("g1_start", PH_GREEN, 2'd1, 1'b0);

        // pause 5 cycles mid green(1); green still totals 4 enabled cycles
        step();
        expect_st("g1_cycle2", PH_GREEN, 2'd1, 1'b0);
        enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            expect_st("pause_frozen", PH_GREEN, 2'd1, 1'b0);
        end
        enable = 1'b1;
        step();
        expect_st("resume_g3", PH_GREEN, 2'd1, 1'b0);
        step();
        expect_st("resume_g4", PH_GREEN, 2'd1, 1'b0);
        step();
        expect_st("resume_yellow", PH_YELLOW, 2'd1, 1'b0);

        // hold is ignored outside green
        hold = 1'b1;
        step();
        expect_st("hold_in_yellow", PH_YELLOW, 2'd1, 1'b0);
        step();
        expect_st("hold_in_yellow_end", PH_ALLRED, 2'd1, 1'b0);
        hold = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            expect_st("g2", PH_GREEN, 2'd2, 1'b0);
        end
        step();
        expect_st("y2", PH_YELLOW, 2'd2, 1'b0);

        // reset mid yellow(2)
        rst = 1'b1;
        step();
        expect_st("rst_mid_yellow", PH_ALLRED, 2'd0, 1'b0);
        rst = 1'b0;
        step();
        expect_st("rst_then_g0", PH_GREEN, 2'd0, 1'b0);

        // random enable/hold/rst: safety invariants every cycle
        for (int c = 0; c < 200; c++) begin
            enable = ($urandom_range(0, 3) != 0);
            hold   = ($urandom_range(0, 1) != 0);
            rst    = ($urandom_range(0, 31) == 0);
            step();
            check_safety();
        end
        rst    = 1'b0;
        enable = 1'b1;
        hold   = 1'b0;

`ifdef TRAFFIC_LIGHT_FLASH_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) step();
        expect_st("fl_pre_g1", PH_GREEN, 2'd1, 1'b0);
        flash = 1'b1;
        step();
        expect_st("fl_on1", PH_FLASH, 2'd1, 1'b1);
        step();
        expect_st("fl_on2", PH_FLASH, 2'd1, 1'b1);
        step();
        expect_st("fl_off1", PH_FLASH, 2'd1, 1'b0);
        step();
        expect_st("fl_off2", PH_FLASH, 2'd1, 1'b0);
        step();
        expect_st("fl_on3", PH_FLASH, 2'd1, 1'b1);
        flash = 1'b0;
        step();
        expect_st("fl_exit_allred", PH_ALLRED, 2'd1, 1'b0);
        step();
        expect_st("fl_exit_g2", PH_GREEN, 2'd2, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
